// File: rtl/dc_motor_ramp_ctrl.sv
// Button-driven duty ramp controller for the dc_motor PWM block.
// Debounced up/down presses set a target level; the FSM wakes the driver and steps level toward target.
module dc_motor_ramp_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned STEP_CYC     = 8,
  parameter int unsigned WAKE_CYC     = 4,
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       estop,
  output logic       inc,
  output logic       dec,
  output logic       nsleep,
  output logic [3:0] level,
  output logic [3:0] target,
  output logic       busy
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned STEP_W = $clog2(STEP_CYC + 1);
  localparam int unsigned WAKE_W = $clog2(WAKE_CYC + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [3:0]  LVL_MAX = 4'd15;

  typedef enum logic [1:0] {SLEEP, WAKE, IDLE, RAMP} state_e;

  // Index 0 = up button, index 1 = down button
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      press_c;

  logic [3:0]        target_q, target_d;
  logic [3:0]        level_q, level_d;
  state_e            state_q, state_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              nsleep_q, nsleep_d;
  logic              busy_q, busy_d;
  logic              step_due_c;

  // Synchronize, debounce and detect debounced rising edges
  always_comb begin
    sync1_d = {btn_down, btn_up};
    sync2_d = sync1_q;
    db_d    = db_q;
    press_c = 2'b00;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_d[i]    = sync2_q[i];
          press_c[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Target update; simultaneous up/down presses cancel
  always_comb begin
    target_d = target_q;
    if (estop) begin
      target_d = 4'd0;
    end else if (press_c[0] && !press_c[1] && target_q != LVL_MAX) begin
      target_d = target_q + 4'd1;
    end else if (press_c[1] && !press_c[0] && target_q != 4'd0) begin
      target_d = target_q - 4'd1;
    end
  end

  // Emergency stop collapses the step interval to a single cycle
  assign step_due_c = estop || (step_cnt_q >= STEP_W'(STEP_CYC - 1));

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    wake_cnt_d = wake_cnt_q;
    step_cnt_d = step_cnt_q;
    idle_cnt_d = idle_cnt_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    unique case (state_q)
      SLEEP: begin
        if (target_q != 4'd0) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (estop || target_q == 4'd0) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
        end else if (wake_cnt_q == WAKE_W'(WAKE_CYC - 1)) begin
          state_d    = RAMP;
          step_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      IDLE: begin
        if (target_q != level_q) begin
          state_d    = RAMP;
          step_cnt_d = '0;
        end else if (level_q == 4'd0) begin
          if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            state_d    = SLEEP;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      RAMP: begin
        if (step_due_c) begin
          step_cnt_d = '0;
          if (target_q > level_q) begin
            inc_d   = 1'b1;
            level_d = level_q + 4'd1;
          end else if (target_q < level_q) begin
            dec_d   = 1'b1;
            level_d = level_q - 4'd1;
          end else begin
            state_d    = IDLE;
            idle_cnt_d = '0;
          end
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      default: state_d = SLEEP;
    endcase
    nsleep_d = (state_d != SLEEP);
    busy_d   = (state_d == WAKE) || (state_d == RAMP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      db_q        <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      target_q    <= 4'd0;
      level_q     <= 4'd0;
      state_q     <= SLEEP;
      wake_cnt_q  <= '0;
      step_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      nsleep_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      target_q    <= target_d;
      level_q     <= level_d;
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      step_cnt_q  <= step_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      nsleep_q    <= nsleep_d;
      busy_q      <= busy_d;
    end
  end

  assign inc    = inc_q;
  assign dec    = dec_q;
  assign nsleep = nsleep_q;
  assign level  = level_q;
  assign target = target_q;
  assign busy   = busy_q;

endmodule

// File: doc/dc_motor_ramp_ctrl.md
DC_MOTOR_RAMP_CTRL -- requirements
Module: dc_motor_ramp_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16: consecutive stable cycles before a synchronized button level is accepted.
REQ-002 Parameter STEP_CYC, default 8: cycles between ramp steps in normal operation.
REQ-003 Parameter WAKE_CYC, default 4: cycles nsleep is held high before the first ramp step after sleep.
REQ-004 Parameter IDLE_TIMEOUT, default 32: cycles at level 0 / target 0 before the driver is put to sleep.
REQ-005 Port clk  input  1: single clock; all state on rising edge.
REQ-006 Port rst  input  1: asynchronous, active-low reset (asserted when 0).
REQ-007 Port btn_up  input  1: raw asynchronous speed-up button.
REQ-008 Port btn_down  input  1: raw asynchronous speed-down button.
REQ-009 Port estop  input  1: synchronous emergency stop, active-high level.
REQ-010 Port inc  output  1: one-cycle step-up pulse to the dc_motor PWM block.
REQ-011 Port dec  output  1: one-cycle step-down pulse to the dc_motor PWM block.
REQ-012 Port nsleep  output  1: motor driver enable, 0 = sleep.
REQ-013 Port level  output  4: current commanded duty level, 0..15.
REQ-014 Port target  output  4: requested duty level, 0..15.
REQ-015 Port busy  output  1: high in states WAKE and RAMP.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYC consecutive equal samples.
REQ-017 A press event SHALL be a one-cycle pulse on the debounced 0->1 transition; holding the button SHALL NOT repeat.
REQ-018 An up event SHALL increment target, saturating at 15; a down event SHALL decrement target, saturating at 0.
REQ-019 Up and down events in the same cycle SHALL both be ignored.
REQ-020 While estop=1, target SHALL be forced to 0 and press events ignored.
REQ-021 FSM states: SLEEP, WAKE, IDLE, RAMP.
REQ-022 SLEEP: nsleep=0; when target>0 -> WAKE with wake counter cleared.
REQ-023 WAKE: nsleep=1; after WAKE_CYC cycles -> RAMP; if estop=1 or target returns to 0 -> IDLE.
REQ-024 IDLE: nsleep=1; target!=level -> RAMP with step counter cleared; level=0 and target=0 for IDLE_TIMEOUT consecutive cycles -> SLEEP.
REQ-025 RAMP: step counter counts STEP_CYC cycles (1 cycle while estop=1); on expiry, if target>level assert inc for one cycle and level+1, if target<level assert dec for one cycle and level-1; counter restarts.
REQ-026 The level update SHALL take effect on the same clock edge that registers the inc/dec pulse.
REQ-027 Direction SHALL be re-evaluated at every step from the current target; a target change mid-ramp SHALL redirect at the next step without restarting the counter.
REQ-028 RAMP with level==target at step evaluation SHALL go to IDLE without a pulse.
REQ-029 inc and dec SHALL never be high in the same cycle, nor be high in any state other than RAMP.
REQ-030 level SHALL never change by more than 1 per step and never wrap.

Reset
REQ-031 With rst=0: state SLEEP, level=0, target=0, inc=0, dec=0, nsleep=0, busy=0, all counters and synchronizer/debounce flops cleared.
REQ-032 Reset assertion mid-ramp SHALL clear outputs asynchronously; no pulse SHALL be issued in the first cycle after release.

Verification
REQ-033 Reset then btn_up held 40 cycles -> target=1, WAKE for 4 cycles (nsleep=1, busy=1), one inc pulse 8 cycles into RAMP, level=1, then IDLE.
REQ-034 Three up presses from level 0 -> target=3; three inc pulses spaced 8 cycles apart; level reaches 3; no dec pulses.
REQ-035 Level 5, estop asserted -> target=0, five dec pulses on consecutive cycles, level=0, IDLE; after 32 cycles nsleep=0.
REQ-036 btn_up bouncing every 3 cycles for 30 cycles, then stable high -> exactly one up event; 16 up presses -> target saturates at 15.
REQ-037 btn_up and btn_down debounced in the same cycle -> target unchanged, no pulse.
REQ-038 rst=0 during RAMP at level 2 -> level=0, nsleep=0, inc=dec=0 immediately; after release state SLEEP.
